// File: rtl/yc_noc_defs.sv
// Shared mesh-router definitions: flit type, output-port arbiter state and limits.
package yc_noc_defs;

    typedef logic [31:0] flit_t;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        HOLD = 2'd1,
        PKT  = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/yc_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module yc_rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from farthest to nearest so the candidate closest to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/yc_out_port_arb.sv
// Per-output-port wormhole arbiter with packet-level round robin.
// Optional per-requester saturating grant counters behind YC_ARB_STATS_EN.
module yc_out_port_arb
    import yc_noc_defs::*;
#(
    parameter int N_REQ = 5,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              in_valid,
    input  logic [N_REQ-1:0]              in_last,
    input  flit_t [N_REQ-1:0]             in_flit,
    output logic [N_REQ-1:0]              in_ready,
    output logic                          out_valid,
    output flit_t                         out_flit,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              gnt_idx,
    output logic                          locked
`ifdef YC_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][CNT_W-1:0]   gnt_cnt
`endif
);

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || CNT_W < 1) begin : g_param_check
        $error("yc_out_port_arb: unsupported N_REQ or CNT_W");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_e       st, st_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] pick_idx, sel;
    logic             pick_found;
    logic             fire, tail;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    yc_rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Outputs are forced quiet while rst is high so the link never sees a flit during reset.
    always_comb begin
        sel       = (st == ARB) ? pick_idx : owner;
        out_valid = !rst && in_valid[sel] && (st != ARB || pick_found);
        out_flit  = in_flit[sel];
        fire      = out_valid && out_ready;
        tail      = in_last[sel];
        in_ready  = '0;
        if (fire) begin
            in_ready[sel] = 1'b1;
        end
        locked    = !rst && (st != ARB);
        gnt_idx   = rst ? '0 : (out_valid ? sel : owner);
    end

    always_comb begin
        st_nxt     = st;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        case (st)
            ARB: begin
                if (fire && tail) begin
                    rr_ptr_nxt = next_idx(sel);
                end else if (out_valid) begin
                    owner_nxt = sel;
                    st_nxt    = fire ? PKT : HOLD;
                end
            end
            HOLD: begin
                if (fire) begin
                    if (tail) begin
                        st_nxt     = ARB;
                        rr_ptr_nxt = next_idx(owner);
                    end else begin
                        st_nxt = PKT;
                    end
                end
            end
            PKT: begin
                if (fire && tail) begin
                    st_nxt     = ARB;
                    rr_ptr_nxt = next_idx(owner);
                end
            end
            default: st_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ARB;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            st     <= st_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

`ifdef YC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt <= '0;
        end else if (fire && gnt_cnt[sel] != {CNT_W{1'b1}}) begin
            gnt_cnt[sel] <= gnt_cnt[sel] + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A stalled owner must keep its flit presented until the link accepts it.
    hold_keeps_valid: assert property (@(posedge clk) disable iff (rst)
        (st == HOLD) |-> in_valid[owner]);
`endif

endmodule

// File: tb/tb_yc_out_port_arb.sv
// Self-checking bench for yc_out_port_arb (N_REQ=3): directed cases plus randomized traffic
// against a packet-level model. Define YC_ARB_STATS_EN to also exercise the grant counters.
module tb_yc_out_port_arb;
    import yc_noc_defs::*;

    localparam int N  = 3;
    localparam int IW = $clog2(N);
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_last;
    flit_t [N-1:0]    in_flit;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    flit_t            out_flit;
    logic             out_ready;
    logic [IW-1:0]    gnt_idx;
    logic             locked;
`ifdef YC_ARB_STATS_EN
    logic [N-1:0][CW-1:0] gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yc_out_port_arb #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .gnt_idx   (gnt_idx),
        .locked    (locked)
`ifdef YC_ARB_STATS_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Packet-level model: the port is either free or held by one requester until its tail
    // is accepted; a free port serves the first valid requester from the priority pointer.
    int holder     = -1;
    int last_owner = 0;
    int prio       = 0;

    function automatic int first_valid(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           esel;
        bit           ev;
        logic [N-1:0] erdy;
        if (rst) begin
            checkOutput("rst_out_valid", int'(out_valid), 0);
            checkOutput("rst_in_ready", int'(in_ready), 0);
            checkOutput("rst_locked", int'(locked), 0);
            checkOutput("rst_gnt_idx", int'(gnt_idx), 0);
            holder     = -1;
            last_owner = 0;
            prio       = 0;
        end else begin
            esel = (holder >= 0) ? holder : first_valid(in_valid, prio);
            ev   = (esel >= 0) ? bit'(in_valid[esel]) : 1'b0;
            erdy = '0;
            if (ev && out_ready) erdy[esel] = 1'b1;
            checkOutput("model_out_valid", int'(out_valid), int'(ev));
            checkOutput("model_in_ready", int'(in_ready), int'(erdy));
            checkOutput("model_locked", int'(locked), (holder >= 0) ? 1 : 0);
            checkOutput("model_gnt_idx", int'(gnt_idx), ev ? esel : last_owner);
            if (ev) begin
                checkOutput("model_out_flit", int'(out_flit), int'(in_flit[esel]));
                if (out_ready && in_last[esel]) begin
                    holder = -1;
                    prio   = (esel + 1) % N;
                end else if (holder < 0) begin
                    holder     = esel;
                    last_owner = esel;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int           cnt[N];
        int           fires;
        bit           v[N];
        int           left[N];
        int           seq[N];
        logic [N-1:0] acc;

        in_valid  = '1;
        in_last   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_flit[i] = 32'h1000_0000 + i;

        // Reset values with every requester asserting
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        doReset();

        // Round robin over single-flit packets
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 90; k++) begin
            applyStimulus(3'b111, 3'b111, 1'b1);
            @(negedge clk);
            checkOutput("rr_order", int'(gnt_idx), k % 3);
            checkOutput("rr_valid", int'(out_valid), 1);
            if (out_valid && out_ready) cnt[gnt_idx]++;
        end
        for (int i = 0; i < N; i++) checkOutput("rr_count", cnt[i], 30);
        doReset();

        // Wormhole lock: 4-flit packet from req0, req1 waiting
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 0) ? 3'b001 : (c < 4) ? 3'b011 : 3'b010,
                          {1'b0, 1'b1, (c == 3)}, 1'b1);
            in_flit[0] = 32'h0A00_0000 + c;
            in_flit[1] = 32'h0B00_0000;
            @(negedge clk);
            checkOutput("wh_gnt", int'(gnt_idx), (c < 4) ? 0 : 1);
            checkOutput("wh_flit", int'(out_flit), (c < 4) ? 32'h0A00_0000 + c : 32'h0B00_0000);
            checkOutput("wh_locked", int'(locked), (c >= 1 && c <= 3) ? 1 : 0);
            checkOutput("wh_ready", int'(in_ready), (c < 4) ? 1 : 2);
        end
        doReset();

        // Stable grant under backpressure; req0 arrives while req2 is stalled
        in_flit[0] = 32'h0D00_0000;
        in_flit[2] = 32'h0C00_0000;
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 2) ? 3'b100 : (c < 6) ? 3'b101 : 3'b001, 3'b111, c >= 5);
            @(negedge clk);
            checkOutput("hold_gnt", int'(gnt_idx), (c < 6) ? 2 : 0);
            checkOutput("hold_flit", int'(out_flit), (c < 6) ? 32'h0C00_0000 : 32'h0D00_0000);
            checkOutput("hold_ready", int'(in_ready), (c < 5) ? 0 : (c == 5) ? 4 : 1);
            checkOutput("hold_locked", int'(locked), (c >= 1 && c <= 5) ? 1 : 0);
        end
        doReset();

        // Lone requester: back-to-back single-flit packets, pointer wrap
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'b010, 3'b010, 1'b1);
            @(negedge clk);
            checkOutput("solo_gnt", int'(gnt_idx), 1);
            if (out_valid && out_ready) fires++;
        end
        checkOutput("solo_fires", fires, 10);
        doReset();

        // Reset mid-packet after moving the pointer away from 0
        applyStimulus(3'b010, 3'b010, 1'b1);
        applyStimulus(3'b001, 3'b000, 1'b1);
        in_flit[0] = 32'h0A00_0000;
        applyStimulus(3'b001, 3'b000, 1'b1);
        in_flit[0] = 32'h0A00_0001;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", int'(out_valid), 0);
        checkOutput("midrst_locked", int'(locked), 0);
        applyStimulus(3'b101, 3'b111, 1'b1);
        rst = 1'b0;
        in_flit[0] = 32'h0D00_0000;
        in_flit[2] = 32'h0C00_0000;
        @(negedge clk);
        checkOutput("postrst_gnt", int'(gnt_idx), 0);
        checkOutput("postrst_locked", int'(locked), 0);
        checkOutput("postrst_flit", int'(out_flit), 32'h0D00_0000);
        doReset();

`ifdef YC_ARB_STATS_EN
        // Saturating grant counters
        for (int c = 0; c < 20; c++) applyStimulus(3'b001, 3'b001, 1'b1);
        applyStimulus(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("cnt_req0", int'(gnt_cnt[0]), 15);
        checkOutput("cnt_req1", int'(gnt_cnt[1]), 0);
        checkOutput("cnt_req2", int'(gnt_cnt[2]), 0);
        doReset();
`endif

        // Randomized traffic: multi-flit packets, owner bubbles, random backpressure
        for (int i = 0; i < N; i++) begin
            v[i]    = 1'b0;
            left[i] = 0;
            seq[i]  = 0;
        end
        acc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    left[i]--;
                    seq[i]++;
                    v[i] = (left[i] > 0) && ($urandom_range(0, 3) != 0);
                end else if (!v[i]) begin
                    if (left[i] == 0) begin
                        if ($urandom_range(0, 2) == 0) begin
                            left[i] = $urandom_range(1, 4);
                            v[i]    = 1'b1;
                        end
                    end else begin
                        v[i] = ($urandom_range(0, 1) == 1);
                    end
                end
                in_valid[i] = v[i];
                in_last[i]  = (left[i] == 1);
                in_flit[i]  = {8'(i), 24'(seq[i])};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = in_valid[i] && in_ready[i];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
